// File: rtl/mem_io_pkg.sv
// Shared decode constants and helpers for the CPU-side memory/I-O responder.
package mem_io_pkg;

  localparam logic [1:0]  IO_BASE_SEL = 2'b11;
  localparam logic [17:0] ADDR_UART   = 18'h30000;
  localparam logic [17:0] ADDR_CLK    = 18'h30004;
  localparam logic [17:0] ADDR_CLK_B1 = 18'h30005;
  localparam logic [17:0] ADDR_CLK_B2 = 18'h30006;
  localparam logic [17:0] ADDR_CLK_B3 = 18'h30007;

  // I/O register selected by the current bus address.
  typedef enum logic [2:0] {
    IO_NONE,
    IO_UART,
    IO_CLK_B0,
    IO_CLK_B1,
    IO_CLK_B2,
    IO_CLK_B3
  } io_reg_e;

  // Full 18-bit match, so any hit also implies the I/O window is selected.
  function automatic io_reg_e io_decode(input logic [17:0] a);
    case (a)
      ADDR_UART:   return IO_UART;
      ADDR_CLK:    return IO_CLK_B0;
      ADDR_CLK_B1: return IO_CLK_B1;
      ADDR_CLK_B2: return IO_CLK_B2;
      ADDR_CLK_B3: return IO_CLK_B3;
      default:     return IO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with fall-through output; used for UART TX and RX.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; the data array carries no reset.
  // NOTE: storage is deliberately not reset -- only pointers/count define validity, and an unreset array maps onto RAM cells.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push+pop leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: sync byte RAM below the I/O window,
// UART TX/RX FIFOs, free-running cycle counter with coherent snapshot, stop flag.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_HWM = (TX_AW+1)'(TX_DEPTH - FULL_MARGIN);

  // Address decode
  logic              io_sel;
  io_reg_e           io_reg;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  assign io_sel           = (cpu_a[17:16] == IO_BASE_SEL);
  assign io_reg           = io_decode(cpu_a[17:0]);
  assign ram_idx          = cpu_a[RAM_AW-1:0];
  assign unused_addr_bits = ^cpu_a[31:18];

  // Response and bookkeeping state
  logic [7:0]  ram_q [2**RAM_AW];
  logic [7:0]  ram_rd_q;
  logic [7:0]  io_rd_d, io_rd_q;
  logic        sel_io_q;
  logic [31:0] cnt_q;
  logic [23:0] snap_q;
  logic        stop_q, ovf_q;

  // FIFO hookup
  logic             tx_push_req, tx_empty, tx_full;
  logic [7:0]       tx_din;
  logic [TX_AW:0]   tx_count;
  logic             rx_pop, rx_empty, rx_full;
  logic [7:0]       rx_dout;
  logic [RX_AW:0]   rx_count_unused;

  // Stop-marker writes push 0x00, bypassing the zero filter on UART writes.
  assign tx_push_req = cpu_wr && ((io_reg == IO_UART && cpu_dout != 8'h00) || io_reg == IO_CLK_B0);
  assign tx_din      = (io_reg == IO_CLK_B0) ? 8'h00 : cpu_dout;
  assign rx_pop      = !cpu_wr && (io_reg == IO_UART);

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push_req),
    .pop    (tx_valid && tx_ready),
    .din    (tx_din),
    .dout   (tx_data),
    .empty  (tx_empty),
    .full   (tx_full),
    .count  (tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid && rx_ready),
    .pop    (rx_pop),
    .din    (rx_data),
    .dout   (rx_dout),
    .empty  (rx_empty),
    .full   (rx_full),
    .count  (rx_count_unused)
  );

  assign tx_valid       = !tx_empty;
  assign rx_ready       = !rx_full;
  assign io_buffer_full = (tx_count >= TX_HWM);
  assign program_stop   = stop_q;
  assign tx_overflow    = ovf_q;
  assign cpu_din        = sel_io_q ? io_rd_q : ram_rd_q;

  // I/O read data for the current address, registered on the next edge.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    io_rd_d = 8'h00;
    case (io_reg)
      IO_UART:   io_rd_d = rx_empty ? 8'h00 : rx_dout;
      IO_CLK_B0: io_rd_d = cnt_q[7:0];
      IO_CLK_B1: io_rd_d = snap_q[7:0];
      IO_CLK_B2: io_rd_d = snap_q[15:8];
      IO_CLK_B3: io_rd_d = snap_q[23:16];
      default:   io_rd_d = 8'h00;
    endcase
  end

  // Byte RAM: write port plus registered read (old data on same-cycle write).
  always_ff @(posedge clk_in) begin
    if (cpu_wr && !io_sel) ram_q[ram_idx] <= cpu_dout;
    ram_rd_q <= ram_q[ram_idx];
  end

  // Response select, cycle counter, snapshot capture and sticky flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_io_q <= 1'b1;
      io_rd_q  <= 8'h00;
      cnt_q    <= '0;
      snap_q   <= '0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sel_io_q <= io_sel;
      io_rd_q  <= io_rd_d;
      cnt_q    <= cnt_q + 32'd1;
      if (!cpu_wr && io_reg == IO_CLK_B0) snap_q <= cnt_q[31:8];
      if (cpu_wr && io_reg == IO_CLK_B0)  stop_q <= 1'b1;
      if (tx_push_req && tx_full)         ovf_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int n_cmp = 0;
  int n_err = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the write captured.
  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
    @(negedge clk_in);
  endtask

  // Called at a negedge; data is on cpu_din at the following negedge.
  task automatic bus_rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
    cpu_a = a; cpu_dout = 8'h00; cpu_wr = 1'b0;
    @(negedge clk_in);
    check(tag, {24'h0, cpu_din}, {24'h0, exp});
  endtask

  task automatic bus_idle();
    cpu_a = 32'h0; cpu_dout = 8'h00; cpu_wr = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus_idle();
    repeat (2) @(negedge clk_in);
    check("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_io_full", {31'h0, io_buffer_full}, 32'h0);
    check("rst_stop", {31'h0, program_stop}, 32'h0);
    check("rst_ovf", {31'h0, tx_overflow}, 32'h0);
    rst_in = 1'b0;

    // Counter starts at 0 on the first edge after reset and counts every cycle.
    bus_rd(32'h30004, 8'h00, "cnt_first");
    bus_rd(32'h30004, 8'h01, "cnt_second");

    // RAM write/read-back, top of RAM, ignored upper address bits.
    bus_wr(32'h00010, 8'hA5);
    bus_rd(32'h00010, 8'hA5, "ram_rd_after_wr");
    bus_wr(32'h1FFFF, 8'h5A);
    bus_rd(32'h1FFFF, 8'h5A, "ram_top");
    bus_rd(32'hFFFC0010, 8'hA5, "ram_alias_hi");
    bus_rd(32'h00020010, 8'hA5, "ram_alias_b17");

    // TX fill with tx_ready low: high-water mark at 14 bytes.
    for (int i = 0; i < 14; i++) begin
      bus_wr(32'h30000, 8'h41 + 8'(i));
      check($sformatf("tx_hwm_%0d", i + 1), {31'h0, io_buffer_full}, {31'h0, (i + 1 >= 14)});
    end
    bus_wr(32'h30000, 8'h00);
    check("tx_zero_ignored", {31'h0, io_buffer_full}, 32'h1);
    bus_wr(32'h30000, 8'h4F);
    bus_wr(32'h30000, 8'h50);
    check("tx_full_no_ovf", {31'h0, tx_overflow}, 32'h0);
    bus_wr(32'h30000, 8'h51);
    check("tx_ovf_set", {31'h0, tx_overflow}, 32'h1);
    bus_idle();

    // Drain in order; high-water flag drops once fewer than 14 remain.
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain_valid_%0d", k), {31'h0, tx_valid}, 32'h1);
      check($sformatf("drain_data_%0d", k), {24'h0, tx_data}, {24'h0, 8'h41 + 8'(k)});
      check($sformatf("drain_hwm_%0d", k), {31'h0, io_buffer_full}, {31'h0, (16 - k >= 14)});
      @(negedge clk_in);
    end
    check("drain_empty", {31'h0, tx_valid}, 32'h0);
    check("ovf_sticky", {31'h0, tx_overflow}, 32'h1);
    tx_ready = 1'b0;

    // RX: two bytes in, three reads out.
    rx_valid = 1'b1; rx_data = 8'h31;
    check("rx_ready_0", {31'h0, rx_ready}, 32'h1);
    @(negedge clk_in);
    rx_data = 8'h32;
    check("rx_ready_1", {31'h0, rx_ready}, 32'h1);
    @(negedge clk_in);
    rx_valid = 1'b0;
    check("rx_ready_2", {31'h0, rx_ready}, 32'h1);
    bus_rd(32'h30000, 8'h31, "rx_rd_0");
    bus_rd(32'h30000, 8'h32, "rx_rd_1");
    bus_rd(32'h30000, 8'h00, "rx_rd_empty");
    bus_idle();

    // RX fill to capacity; a 17th byte is refused.
    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'h60 + 8'(i);
      @(negedge clk_in);
    end
    rx_valid = 1'b0;
    check("rx_full_not_ready", {31'h0, rx_ready}, 32'h0);
    bus_rd(32'h30000, 8'h60, "rx_full_head");
    check("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);

    // Other I/O addresses: no write effect, read as zero.
    bus_wr(32'h30001, 8'h77);
    check("io_other_wr", {31'h0, tx_valid}, 32'h0);
    bus_rd(32'h30008, 8'h00, "io_other_rd");

    // Counter near wrap: coherent snapshot, then wrap observed.
    cpu_a = 32'h30004; cpu_wr = 1'b0;
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    @(negedge clk_in);
    check("snap_b0", {24'h0, cpu_din}, 32'hFE);
    bus_rd(32'h30005, 8'hFF, "snap_b1");
    bus_rd(32'h30006, 8'hFF, "snap_b2");
    bus_rd(32'h30007, 8'hFF, "snap_b3");
    bus_rd(32'h30004, 8'h02, "wrap_b0");
    bus_rd(32'h30005, 8'h00, "wrap_b1");
    bus_rd(32'h30007, 8'h00, "wrap_b3");

    // Stop marker, sticky flag, then reset mid-drain.
    bus_wr(32'h30004, 8'h99);
    check("stop_set", {31'h0, program_stop}, 32'h1);
    check("stop_marker_valid", {31'h0, tx_valid}, 32'h1);
    check("stop_marker_data", {24'h0, tx_data}, 32'h00);
    bus_wr(32'h30000, 8'h42);
    bus_wr(32'h30000, 8'h43);
    bus_idle();
    @(negedge clk_in);
    check("stop_sticky", {31'h0, program_stop}, 32'h1);
    tx_ready = 1'b1;
    check("emit_0", {24'h0, tx_data}, 32'h00);
    @(negedge clk_in);
    check("emit_1", {24'h0, tx_data}, 32'h42);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst2_stop", {31'h0, program_stop}, 32'h0);
    check("rst2_ovf", {31'h0, tx_overflow}, 32'h0);
    check("rst2_io_full", {31'h0, io_buffer_full}, 32'h0);
    check("rst2_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst2_cpu_din", {24'h0, cpu_din}, 32'h0);
    rst_in = 1'b0;
    bus_rd(32'h00010, 8'hA5, "ram_kept");
    bus_rd(32'h30000, 8'h00, "rx_flushed");
    check("tx_flushed", {31'h0, tx_valid}, 32'h0);
    bus_idle();
    @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
